// File: rtl/fu_pkg.sv
// Shared encodings for the external ALU functional unit: opcodes, CSR bits,
// DE<->FU bus field positions and the sequencing FSM states.
package fu_pkg;

    localparam int DBITS    = 32;
    localparam int OP3_BITS = 31;
    localparam int ITERS    = 32;

    localparam logic [3:0] FU_ADD = 4'd0;
    localparam logic [3:0] FU_SUB = 4'd1;
    localparam logic [3:0] FU_AND = 4'd2;
    localparam logic [3:0] FU_OR  = 4'd3;
    localparam logic [3:0] FU_XOR = 4'd4;
    localparam logic [3:0] FU_MUL = 4'd5;
    localparam logic [3:0] FU_DIV = 4'd6;
    localparam logic [3:0] FU_REM = 4'd7;

    localparam int CSR_DONE = 0;
    localparam int CSR_ERR  = 1;
    localparam int CSR_OVF  = 2;
    localparam int CSR_BITS = 3;

    // decode -> FU bus
    localparam int DE_W         = 71;
    localparam int DE_WR_ALUOP  = 0;
    localparam int DE_WR_OP1    = 1;
    localparam int DE_WR_OP2    = 2;
    localparam int DE_WDATA_LSB = 3;
    localparam int DE_RD_OP3    = 35;

    // FU -> decode bus
    localparam int FU_W       = 35;
    localparam int FU_OP3_LSB = 0;
    localparam int FU_CSR_LSB = 31;
    localparam int FU_BUSY    = 34;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } fu_state_e;

    function automatic logic is_divrem(input logic [3:0] op);
        return (op == FU_DIV) || (op == FU_REM);
    endfunction

endpackage

// File: rtl/ext_alu_iter.sv
// Iterative MUL/DIV/REM datapath: unsigned shift-add multiply or restoring
// divide on operand magnitudes, with the sign applied to the final step.
module ext_alu_iter
    import fu_pkg::*;
#(
    parameter int W     = 32,
    parameter int ITERS = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] result,
    output logic         hi_ok
);
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_mul_q, is_mul_d;
    logic          is_rem_q, is_rem_d;
    logic          neg_q, neg_d;
    logic [W-1:0]  mag_q, mag_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  lo_q, lo_d;

    logic [W:0]     sum;
    logic [W:0]     shifted;
    logic [W:0]     trial;
    logic [W-1:0]   step_acc;
    logic [W-1:0]   step_lo;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W-1:0]   mag_res;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] sprod;

    always_comb begin
        mag_a = a[W-1] ? (~a + 1'b1) : a;
        mag_b = b[W-1] ? (~b + 1'b1) : b;

        sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_q} : {(W+1){1'b0}});
        shifted = {acc_q, lo_q[W-1]};
        trial   = shifted - {1'b0, mag_q};

        if (is_mul_q) begin
            step_acc = sum[W:1];
            step_lo  = {sum[0], lo_q[W-1:1]};
        end else if (!trial[W]) begin
            step_acc = trial[W-1:0];
            step_lo  = {lo_q[W-2:0], 1'b1};
        end else begin
            step_acc = shifted[W-1:0];
            step_lo  = {lo_q[W-2:0], 1'b0};
        end

        active_d = active_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
        is_rem_d = is_rem_q;
        neg_d    = neg_q;
        mag_d    = mag_q;
        acc_d    = acc_q;
        lo_d     = lo_q;

        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            is_mul_d = (op == FU_MUL);
            is_rem_d = (op == FU_REM);
            neg_d    = (op == FU_REM) ? a[W-1] : (a[W-1] ^ b[W-1]);
            mag_d    = (op == FU_MUL) ? mag_a : mag_b;
            lo_d     = (op == FU_MUL) ? mag_b : mag_a;
            acc_d    = '0;
        end else if (active_q) begin
            acc_d = step_acc;
            lo_d  = step_lo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                active_d = 1'b0;
            end
        end
    end

    // Result is taken from the final step's values so it lands with done.
    always_comb begin
        prod    = {step_acc, step_lo};
        sprod   = neg_q ? (~prod + 1'b1) : prod;
        mag_res = is_rem_q ? step_acc : step_lo;
        if (is_mul_q) begin
            result = sprod[W-1:0];
            hi_ok  = (sprod[2*W-1:W] == {W{sprod[W-1]}});
        end else begin
            result = neg_q ? (~mag_res + 1'b1) : mag_res;
            hi_ok  = 1'b1;
        end
    end

    assign done = active_q && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
            mag_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
            is_rem_q <= is_rem_d;
            neg_q    <= neg_d;
            mag_q    <= mag_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: rtl/ext_alu_fu.sv
// External ALU functional unit: operand registers, sequencing FSM, CSR and
// DE<->FU bus packing around the iterative MUL/DIV datapath.
module ext_alu_fu
    import fu_pkg::*;
#(
    parameter int DBITS    = fu_pkg::DBITS,
    parameter int OP3_BITS = fu_pkg::OP3_BITS,
    parameter int ITERS    = fu_pkg::ITERS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DBITS+38:0]     from_DE_to_FU,
    output logic [OP3_BITS+3:0]   from_FU_to_DE
);
    logic             wr_aluop;
    logic             wr_op1;
    logic             wr_op2;
    logic             rd_op3;
    logic [DBITS-1:0] wdata;
    logic             unused_pad;

    assign wr_aluop   = from_DE_to_FU[DE_WR_ALUOP];
    assign wr_op1     = from_DE_to_FU[DE_WR_OP1];
    assign wr_op2     = from_DE_to_FU[DE_WR_OP2];
    assign wdata      = from_DE_to_FU[DBITS+2:3];
    assign rd_op3     = from_DE_to_FU[DBITS+3];
    assign unused_pad = ^from_DE_to_FU[DBITS+38:DBITS+4];

    fu_state_e             state_q, state_d;
    logic [3:0]            aluop_q, aluop_d;
    logic [DBITS-1:0]      op1_q, op1_d;
    logic [DBITS-1:0]      op2_q, op2_d;
    logic [OP3_BITS-1:0]   op3_q, op3_d;
    logic [CSR_BITS-1:0]   csr_q, csr_d;

    logic [DBITS-1:0] op1_eff;
    logic [DBITS-1:0] op2_eff;
    logic [3:0]       new_op;
    logic             start_long;
    logic [DBITS-1:0] short_r;
    logic             short_err;
    logic             iter_done;
    logic [DBITS-1:0] iter_result;
    logic             iter_hi_ok;

    // Result fits the return bus only if the bits above the op3 sign agree.
    function automatic logic range_ovf(input logic [DBITS-1:0] r);
        return (|r[DBITS-1:OP3_BITS-1]) && !(&r[DBITS-1:OP3_BITS-1]);
    endfunction

    always_comb begin
        op1_eff    = wr_op1 ? wdata : op1_q;
        op2_eff    = wr_op2 ? wdata : op2_q;
        new_op     = wdata[3:0];
        start_long = (state_q == IDLE) && wr_aluop &&
                     ((new_op == FU_MUL) || (is_divrem(new_op) && (op2_eff != '0)));
    end

    // Single-cycle ops; DIV/REM only reach here with a zero divisor.
    always_comb begin
        short_err = 1'b0;
        case (aluop_q)
            FU_ADD:  short_r = op1_q + op2_q;
            FU_SUB:  short_r = op1_q - op2_q;
            FU_AND:  short_r = op1_q & op2_q;
            FU_OR:   short_r = op1_q | op2_q;
            FU_XOR:  short_r = op1_q ^ op2_q;
            FU_DIV, FU_REM: begin
                short_r   = '1;
                short_err = 1'b1;
            end
            default: begin
                short_r   = '0;
                short_err = 1'b1;
            end
        endcase
    end

    ext_alu_iter #(
        .W     (DBITS),
        .ITERS (ITERS)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (start_long),
        .op     (new_op),
        .a      (op1_eff),
        .b      (op2_eff),
        .done   (iter_done),
        .result (iter_result),
        .hi_ok  (iter_hi_ok)
    );

    always_comb begin
        state_d = state_q;
        aluop_d = aluop_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        op3_d   = op3_q;
        csr_d   = csr_q;
        case (state_q)
            IDLE: begin
                if (wr_op1) op1_d = wdata;
                if (wr_op2) op2_d = wdata;
                if (wr_aluop) begin
                    aluop_d         = new_op;
                    csr_d[CSR_DONE] = 1'b0;
                    state_d         = start_long ? LONG : SHORT;
                end else if (rd_op3 && csr_q[CSR_DONE]) begin
                    csr_d[CSR_DONE] = 1'b0;
                end
            end
            SHORT: begin
                op3_d          = short_r[OP3_BITS-1:0];
                csr_d[CSR_DONE] = 1'b1;
                csr_d[CSR_ERR]  = short_err;
                csr_d[CSR_OVF]  = range_ovf(short_r);
                state_d         = IDLE;
            end
            LONG: begin
                if (iter_done) begin
                    op3_d           = iter_result[OP3_BITS-1:0];
                    csr_d[CSR_DONE] = 1'b1;
                    csr_d[CSR_ERR]  = 1'b0;
                    csr_d[CSR_OVF]  = range_ovf(iter_result) || !iter_hi_ok;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            aluop_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            op3_q   <= '0;
            csr_q   <= '0;
        end else begin
            state_q <= state_d;
            aluop_q <= aluop_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            op3_q   <= op3_d;
            csr_q   <= csr_d;
        end
    end

    assign from_FU_to_DE = {(state_q != IDLE), csr_q, op3_q};

endmodule

// File: tb/tb_ext_alu_fu.sv
// Scoreboard bench for ext_alu_fu: stimulus pushes expected completions,
// a negedge monitor pops and checks them when busy falls.
module tb_ext_alu_fu;

    logic        clk = 1'b0;
    logic        reset;
    logic [70:0] de;
    logic [34:0] fu;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [30:0] op3;
        logic [2:0]  csr;
        int          cycles;
        string       name;
    } exp_t;

    exp_t sb[$];

    ext_alu_fu dut (
        .clk           (clk),
        .reset         (reset),
        .from_DE_to_FU (de),
        .from_FU_to_DE (fu)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts busy cycles and checks each completion against the queue.
    initial begin
        logic prev_busy;
        int   busy_cnt;
        exp_t e;
        prev_busy = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
                busy_cnt  = 0;
            end else begin
                if (fu[34]) begin
                    busy_cnt++;
                end else if (prev_busy) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: op3=%0h csr=%b expected none", fu[30:0], fu[33:31]);
                    end else begin
                        e = sb.pop_front();
                        $display("txn %s: op3=%h csr=%b busy_cycles=%0d (exp %h %b %0d)",
                                 e.name, fu[30:0], fu[33:31], busy_cnt, e.op3, e.csr, e.cycles);
                        chk({e.name, "_op3"}, 64'(fu[30:0]), 64'(e.op3));
                        chk({e.name, "_csr"}, 64'(fu[33:31]), 64'(e.csr));
                        chk({e.name, "_busy"}, 64'(busy_cnt), 64'(e.cycles));
                    end
                    busy_cnt = 0;
                end
                prev_busy = fu[34];
            end
        end
    end

    task automatic de_write(input logic [2:0] wr, input logic [31:0] d, input logic rd);
        de = {35'b0, rd, d, wr};
        @(posedge clk);
        #1;
        de = '0;
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        de_write(3'b010, a, 1'b0);
        de_write(3'b100, b, 1'b0);
    endtask

    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [30:0] e_op3, input logic [2:0] e_csr, input int cyc);
        exp_t e;
        e.op3 = e_op3; e.csr = e_csr; e.cycles = cyc; e.name = name;
        sb.push_back(e);
        de_write(3'b001, {28'b0, op}, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d completions pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        exp_t e;
        de    = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_idle_bus", 64'(fu), 64'h0);
        end
        @(posedge clk);
        #1;

        // ADD, then a held read clears done without touching op3
        set_ops(32'd7, 32'd5);
        run_op("add_7_5", 4'd0, 31'd12, 3'b001, 1);
        wait_drain("add_7_5");
        de = {35'b0, 1'b1, 32'b0, 3'b000};
        repeat (3) @(posedge clk);
        #1;
        de = '0;
        chk("rd_clears_done_csr", 64'(fu[33:31]), 64'h0);
        chk("rd_keeps_op3", 64'(fu[30:0]), 64'd12);

        // MUL with ignored mid-op operand write and read
        set_ops(-32'sd6, 32'd7);
        run_op("mul_m6_7", 4'd5, 31'h7FFFFFD6, 3'b001, 32);
        repeat (5) @(posedge clk);
        #1;
        de_write(3'b010, 32'd99, 1'b0);
        de_write(3'b000, 32'd0, 1'b1);
        wait_drain("mul_m6_7");
        run_op("add_after_ignored_wr", 4'd0, 31'd1, 3'b001, 1);
        wait_drain("add_after_ignored_wr");

        // DIV / REM signed, and by zero
        set_ops(-32'sd17, 32'd5);
        run_op("div_m17_5", 4'd6, 31'h7FFFFFFD, 3'b001, 32);
        wait_drain("div_m17_5");
        run_op("rem_m17_5", 4'd7, 31'h7FFFFFFE, 3'b001, 32);
        wait_drain("rem_m17_5");
        de_write(3'b100, 32'd0, 1'b0);
        run_op("div_by_0", 4'd6, 31'h7FFFFFFF, 3'b011, 1);
        wait_drain("div_by_0");
        run_op("rem_by_0", 4'd7, 31'h7FFFFFFF, 3'b011, 1);
        wait_drain("rem_by_0");

        // Overflow and invalid opcode
        set_ops(32'h40000000, 32'd1);
        run_op("add_ovf", 4'd0, 31'h40000001, 3'b101, 1);
        wait_drain("add_ovf");
        run_op("invalid_9", 4'd9, 31'd0, 3'b011, 1);
        wait_drain("invalid_9");
        set_ops(32'h80000000, 32'hFFFFFFFF);
        run_op("div_min_m1", 4'd6, 31'd0, 3'b101, 32);
        wait_drain("div_min_m1");
        set_ops(32'h00010000, 32'h00010000);
        run_op("mul_hi_ovf", 4'd5, 31'd0, 3'b101, 32);
        wait_drain("mul_hi_ovf");

        // Logic ops and SUB
        set_ops(32'h0000F0F0, 32'h0000FF00);
        run_op("and", 4'd2, 31'h0000F000, 3'b001, 1);
        wait_drain("and");
        run_op("or", 4'd3, 31'h0000FFF0, 3'b001, 1);
        wait_drain("or");
        run_op("xor", 4'd4, 31'h00000FF0, 3'b001, 1);
        wait_drain("xor");
        set_ops(32'd3, 32'd10);
        run_op("sub_3_10", 4'd1, 31'h7FFFFFF9, 3'b001, 1);
        wait_drain("sub_3_10");

        // Same-cycle op1 write and ADD start: wdata 0x20 -> op1=0x20, aluop=0
        de_write(3'b100, 32'd3, 1'b0);
        e.op3 = 31'h23; e.csr = 3'b001; e.cycles = 1; e.name = "same_cycle_op1_add";
        sb.push_back(e);
        de_write(3'b011, 32'h00000020, 1'b0);
        wait_drain("same_cycle_op1_add");

        // Reset aborts a DIV in flight
        set_ops(32'd100, 32'd3);
        de_write(3'b001, 32'd6, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        chk("busy_before_abort", 64'(fu[34]), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_bus_zero", 64'(fu), 64'h0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_late_result", 64'(fu), 64'h0);
        set_ops(32'd2, 32'd3);
        run_op("add_after_reset", 4'd0, 31'd5, 3'b001, 1);
        wait_drain("add_after_reset");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
